// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of NUM_CH up/down counters with modulus, wrap/saturate, tc and sticky ovf
// Optional snapshot registers enabled by defining COUNTER_BANK_SNAPSHOT_EN.
module counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9,
  parameter int SAT_MODE  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef COUNTER_BANK_SNAPSHOT_EN
  input  logic                      snap,
  output logic [NUM_CH*WIDTH-1:0]   snap_cnt,
  output logic                      snap_vld,
`endif
  input  logic [NUM_CH-1:0]         up,
  input  logic [NUM_CH-1:0]         down,
  input  logic [NUM_CH-1:0]         clr,
  input  logic [NUM_CH-1:0]         load,
  input  logic [NUM_CH*WIDTH-1:0]   load_val,
  input  logic [NUM_CH-1:0]         ovf_clr,
  output logic [NUM_CH*WIDTH-1:0]   cnt,
  output logic [NUM_CH-1:0]         tc,
  output logic [NUM_CH-1:0]         ovf
);

  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_COUNT);

  if (MAX_COUNT < 1 || MAX_COUNT > (2**WIDTH) - 1) begin : g_bad_max_count
    $error("counter_bank: MAX_COUNT must be in 1..2**WIDTH-1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic             tc_q;
    logic             ovf_q;
    logic [WIDTH:0]   cur;
    logic [WIDTH:0]   lv;
    logic [WIDTH:0]   nxt;
    logic             tc_nxt;
    logic             ev;

    assign cur = {1'b0, cnt_q};
    assign lv  = {1'b0, load_val[i*WIDTH +: WIDTH]};

    // ev marks a lost or wrapped count; tc marks reaching/crossing a limit
    always_comb begin
      nxt    = cur;
      tc_nxt = 1'b0;
      ev     = 1'b0;
      if (clr[i]) begin
        nxt = '0;
      end else if (load[i]) begin
        nxt = (lv > MAX_W) ? MAX_W : lv;
      end else if (up[i] && !down[i]) begin
        if (cur == MAX_W) begin
          ev = 1'b1;
          if (SAT_MODE == 0) begin
            nxt    = '0;
            tc_nxt = 1'b1;
          end
        end else begin
          nxt    = cur + 1'b1;
          tc_nxt = (SAT_MODE != 0) && (nxt == MAX_W);
        end
      end else if (down[i] && !up[i]) begin
        if (cur == '0) begin
          ev = 1'b1;
          if (SAT_MODE == 0) begin
            nxt    = MAX_W;
            tc_nxt = 1'b1;
          end
        end else begin
          nxt    = cur - 1'b1;
          tc_nxt = (SAT_MODE != 0) && (nxt == '0);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= nxt[WIDTH-1:0];
        tc_q  <= tc_nxt;
        ovf_q <= ev | (ovf_q & ~ovf_clr[i]);
      end
    end

    assign cnt[i*WIDTH +: WIDTH] = cnt_q;
    assign tc[i]                 = tc_q;
    assign ovf[i]                = ovf_q;
  end

`ifdef COUNTER_BANK_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_cnt <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= snap;
      if (snap) snap_cnt <= cnt;
    end
  end
`endif

endmodule
